// File: rtl/anti_theft_controller.sv
// ---------------------------------------------------------------------------
// anti_theft_controller
//
// Main FSM of the automotive anti-theft system and the client side of the
// countdown timer. Decides when the system arms, triggers and sounds the
// alarm, drives the siren and status LED, and issues start/value requests to
// the timer while consuming its expired and 1 Hz / 2 Hz tick outputs.
//
// Optional feature macro: REPROGRAM_EN
//   defined   : adds param_sel/time_value; reprogram also writes the selected
//               interval register (0 arm, 1 driver, 2 passenger, 3 alarm).
//   undefined : intervals are the parameter constants; reprogram only forces
//               ARMED.
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous, active-low reset
//   ignition       in   1 = ignition on
//   door_driver    in   1 = driver door open
//   door_pass      in   1 = passenger door open
//   reprogram      in   1-cycle strobe, forces ARMED
//   param_sel      in   [1:0] interval select        (REPROGRAM_EN only)
//   time_value     in   [3:0] new interval in seconds (REPROGRAM_EN only)
//   expired        in   timer expiry level
//   one_hz_enable  in   1-cycle 1 Hz tick
//   two_hz_enable  in   1-cycle 2 Hz tick
//   start_timer    out  1-cycle start request to the timer
//   value          out  [3:0] interval, valid while start_timer=1
//   siren          out  alarm output
//   status_led     out  status indicator
//   state          out  [2:0] current state code (debug)
// ---------------------------------------------------------------------------
module anti_theft_controller #(
  parameter logic [3:0] T_ARM_DELAY       = 4'd6,
  parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
  parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       reprogram,
`ifdef REPROGRAM_EN
  input  logic [1:0] param_sel,
  input  logic [3:0] time_value,
`endif
  input  logic       expired,
  input  logic       one_hz_enable,
  input  logic       two_hz_enable,
  output logic       start_timer,
  output logic [3:0] value,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGERED  = 3'd1,
    ST_ALARM      = 3'd2,
    ST_ALARM_HOLD = 3'd3,
    ST_DISARMED   = 3'd4,
    ST_WAIT_OPEN  = 3'd5,
    ST_WAIT_CLOSE = 3'd6,
    ST_ARM_DELAY  = 3'd7
  } state_e;

  state_e     state_q, state_d, prev_q, owner_q, owner_d;
  logic       pend_q, pend_d, busy_q, busy_d;
  logic [3:0] pend_val_q, pend_val_d, value_q, value_d;
  logic       start_q, start_d, siren_q, siren_d, led_q, led_d;

  logic       req, drop;
  logic [3:0] req_val;
  logic [3:0] t_arm, t_drv, t_pas, t_alm;

`ifdef REPROGRAM_EN
  logic [3:0] t_arm_q, t_drv_q, t_pas_q, t_alm_q;

  // NOTE: these four registers are configuration, not scratch memory, so they
  // get a reset value; the controller must use the defaults straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t_arm_q <= T_ARM_DELAY;
      t_drv_q <= T_DRIVER_DELAY;
      t_pas_q <= T_PASSENGER_DELAY;
      t_alm_q <= T_ALARM_ON;
    end else if (reprogram) begin
      case (param_sel)
        2'd0:    t_arm_q <= time_value;
        2'd1:    t_drv_q <= time_value;
        2'd2:    t_pas_q <= time_value;
        default: t_alm_q <= time_value;
      endcase
    end
  end

  assign t_arm = t_arm_q;
  assign t_drv = t_drv_q;
  assign t_pas = t_pas_q;
  assign t_alm = t_alm_q;
`else
  assign t_arm = T_ARM_DELAY;
  assign t_drv = T_DRIVER_DELAY;
  assign t_pas = T_PASSENGER_DELAY;
  assign t_alm = T_ALARM_ON;
`endif

  // The timer ignores start while running, so a start is only issued once our
  // mirror of its state (busy) says it is idle.
  logic issue, expiry_seen, timeout;
  assign issue       = pend_q && !busy_q;
  // An expiry seen while start is on the wire belongs to the previous interval.
  assign expiry_seen = expired && busy_q && !start_q;
  // Only an expiry of the interval this state itself asked for, with nothing
  // newer queued, counts as a timeout; anything else is a stale, abandoned one.
  assign timeout     = expiry_seen && (owner_q == state_q) && !pend_q;

  // Next-state logic and timer requests.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d = state_q;
    req     = 1'b0;
    req_val = '0;
    drop    = 1'b0;
    if (reprogram) begin
      state_d = ST_ARMED;
      drop    = 1'b1;
    end else if (ignition && state_q != ST_DISARMED) begin
      state_d = ST_DISARMED;
      drop    = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (door_driver) begin
            state_d = ST_TRIGGERED;
            req     = 1'b1;
            req_val = t_drv;
          end else if (door_pass) begin
            state_d = ST_TRIGGERED;
            req     = 1'b1;
            req_val = t_pas;
          end
        end
        ST_TRIGGERED: if (timeout) state_d = ST_ALARM;
        ST_ALARM: begin
          if (!door_driver && !door_pass) begin
            state_d = ST_ALARM_HOLD;
            req     = 1'b1;
            req_val = t_alm;
          end
        end
        ST_ALARM_HOLD: begin
          if (door_driver || door_pass) state_d = ST_ALARM;
          else if (timeout)             state_d = ST_ARMED;
        end
        ST_DISARMED:  if (!ignition)  state_d = ST_WAIT_OPEN;
        ST_WAIT_OPEN: if (door_driver) state_d = ST_WAIT_CLOSE;
        ST_WAIT_CLOSE: begin
          if (!door_driver) begin
            state_d = ST_ARM_DELAY;
            req     = 1'b1;
            req_val = t_arm;
          end
        end
        ST_ARM_DELAY: begin
          if (door_driver || door_pass) state_d = ST_WAIT_CLOSE;
          else if (timeout)             state_d = ST_ARMED;
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  // Timer handshake and registered outputs.
  always_comb begin
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    busy_d     = busy_q;
    owner_d    = owner_q;
    start_d    = 1'b0;
    value_d    = value_q;
    if (expiry_seen) busy_d = 1'b0;
    if (issue) begin
      start_d = 1'b1;
      value_d = pend_val_q;
      pend_d  = 1'b0;
      busy_d  = 1'b1;
      owner_d = state_q;
    end
    // A newer request overwrites whatever is still waiting for the timer.
    if (req) begin
      pend_d     = 1'b1;
      pend_val_d = req_val;
    end
    if (drop) pend_d = 1'b0;

    siren_d = (state_q == ST_ALARM) || (state_q == ST_ALARM_HOLD);
    case (state_q)
      // The first cycle in ARMED clears the LED so the blink starts dark.
      ST_ARMED:      led_d = (prev_q != ST_ARMED) ? 1'b0 :
                             (one_hz_enable ? ~led_q : led_q);
      ST_TRIGGERED:  led_d = 1'b1;
      ST_ALARM,
      ST_ALARM_HOLD: led_d = two_hz_enable ? ~led_q : led_q;
      default:       led_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ARMED;
      prev_q     <= ST_ARMED;
      owner_q    <= ST_ARMED;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      value_q    <= '0;
      siren_q    <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= state_q;
      owner_q    <= owner_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      value_q    <= value_d;
      siren_q    <= siren_d;
      led_q      <= led_d;
    end
  end

  assign start_timer = start_q;
  assign value       = value_q;
  assign siren       = siren_q;
  assign status_led  = led_q;
  assign state       = state_q;

endmodule
